// File: rtl/conf_int_mul_issue_ctrl_if.sv
// Operand/result handshake bundle between the issue controller and its client.
// The slave side is the controller; the master side is the requester plus multiplier.
interface conf_int_mul_issue_ctrl_if #(
    parameter int DATA_PATH_BITWIDTH = 24
);
    logic                            in_valid;
    logic                            in_ready;
    logic [DATA_PATH_BITWIDTH-1:0]   in_a;
    logic [DATA_PATH_BITWIDTH-1:0]   in_b;
    logic                            in_apx;
    logic                            mul_racc;
    logic                            mul_rapx;
    logic [DATA_PATH_BITWIDTH-1:0]   mul_a;
    logic [DATA_PATH_BITWIDTH-1:0]   mul_b;
    logic [DATA_PATH_BITWIDTH-3:0]   mul_d;
    logic                            out_valid;
    logic                            out_ready;
    logic [DATA_PATH_BITWIDTH-3:0]   out_d;
    logic                            out_apx;
    logic                            mode;

    modport master (
        output in_valid, in_a, in_b, in_apx, mul_d, out_ready,
        input  in_ready, mul_racc, mul_rapx, mul_a, mul_b, out_valid, out_d, out_apx, mode
    );

    modport slave (
        input  in_valid, in_a, in_b, in_apx, mul_d, out_ready,
        output in_ready, mul_racc, mul_rapx, mul_a, mul_b, out_valid, out_d, out_apx, mode
    );
endinterface

// File: rtl/conf_int_mul_issue_ctrl.sv
// Issue controller for a configurable-accuracy multiplier: accepts one operand pair,
// switches the multiplier mode when needed, waits out the latency and holds the result.
module conf_int_mul_issue_ctrl #(
    parameter int OP_BITWIDTH        = 16,
    parameter int DATA_PATH_BITWIDTH = 24,
    parameter int LAT                = 2,
    parameter int SWITCH_CYCLES      = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    conf_int_mul_issue_ctrl_if.slave bus
);
    localparam int DPW   = DATA_PATH_BITWIDTH;
    localparam int RW    = DPW - 2;
    localparam int CMAX  = (LAT > SWITCH_CYCLES) ? LAT : SWITCH_CYCLES;
    localparam int CNT_W = $clog2(CMAX + 1);

    if (LAT < 1 || SWITCH_CYCLES < 1 || OP_BITWIDTH > DPW) begin : g_param_chk
        $error("conf_int_mul_issue_ctrl: illegal parameter combination");
    end

    typedef enum logic [1:0] {IDLE, SWITCH, WAIT, HOLD} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               mode_q, mode_d;
    logic               req_apx_q;
    logic [DPW-1:0]     mul_a_q, mul_b_q;
    logic               racc_q, rapx_q;
    logic               out_valid_q;
    logic [RW-1:0]      out_d_q;
    logic               out_apx_q;

    logic               accept;
    logic               need_switch;
    logic               capture;
    logic               release_hold;

    assign accept       = bus.in_valid && (state_q == IDLE);
    assign need_switch  = (bus.in_apx != mode_q);
    assign capture      = (state_q == WAIT) && (cnt_q == '0);
    assign release_hold = (state_q == HOLD) && bus.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (need_switch) begin
                        state_d = SWITCH;
                        cnt_d   = CNT_W'(SWITCH_CYCLES - 1);
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(LAT - 1);
                    end
                end
            end
            SWITCH: begin
                if (cnt_q == '0) begin
                    // The multiplier has settled in the new mode; start the result wait.
                    mode_d  = req_apx_q;
                    state_d = WAIT;
                    cnt_d   = CNT_W'(LAT - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.mode      = mode_q;
        bus.mul_racc  = racc_q;
        bus.mul_rapx  = rapx_q;
        bus.mul_a     = mul_a_q;
        bus.mul_b     = mul_b_q;
        bus.out_valid = out_valid_q;
        bus.out_d     = out_d_q;
        bus.out_apx   = out_apx_q;
    end

    // Operand, mode-request pulse and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_apx_q   <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            racc_q      <= 1'b0;
            rapx_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_d_q     <= '0;
            out_apx_q   <= 1'b0;
        end else begin
            if (accept) begin
                mul_a_q   <= bus.in_a;
                mul_b_q   <= bus.in_b;
                req_apx_q <= bus.in_apx;
            end
            // Pulses land exactly in the first SWITCH cycle.
            racc_q <= accept && need_switch && !bus.in_apx;
            rapx_q <= accept && need_switch &&  bus.in_apx;
            if (capture) begin
                out_d_q     <= bus.mul_d;
                out_apx_q   <= req_apx_q;
                out_valid_q <= 1'b1;
            end else if (release_hold) begin
                out_valid_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_conf_int_mul_issue_ctrl.sv
// Randomized plus directed bench for conf_int_mul_issue_ctrl against a transaction-level model.
module tb_conf_int_mul_issue_ctrl;
    localparam int DPW = 24;
    localparam int RW  = DPW - 2;
    localparam int LAT = 2;
    localparam int SW  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    conf_int_mul_issue_ctrl_if #(.DATA_PATH_BITWIDTH(DPW)) bus ();

    conf_int_mul_issue_ctrl #(
        .OP_BITWIDTH(16), .DATA_PATH_BITWIDTH(DPW), .LAT(LAT), .SWITCH_CYCLES(SW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Multiplier stand-in: product of the registered operands, truncated to the result width.
    logic [2*DPW-1:0] prod;
    always_comb begin
        prod      = (2*DPW)'(bus.mul_a) * (2*DPW)'(bus.mul_b);
        bus.mul_d = prod[RW-1:0];
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Transaction model: 0 = free, 1 = request in flight, 2 = result held.
    int              cyc;
    int              m_phase;
    int              m_done_at;
    int              m_pulse_at;
    int              m_mode_at;
    logic            m_mode;
    logic            m_req;
    logic [RW-1:0]   m_res;
    logic [DPW-1:0]  e_a, e_b;
    logic            e_valid;
    logic [RW-1:0]   e_d;
    logic            e_apx;

    function automatic void model_reset();
        m_phase    = 0;
        m_done_at  = -1;
        m_pulse_at = -1;
        m_mode_at  = -1;
        m_mode     = 1'b0;
        m_req      = 1'b0;
        m_res      = '0;
        e_a        = '0;
        e_b        = '0;
        e_valid    = 1'b0;
        e_d        = '0;
        e_apx      = 1'b0;
    endfunction

    function automatic void model_edge(input logic v, input logic [DPW-1:0] a, input logic [DPW-1:0] b,
                                       input logic apx, input logic ordy);
        logic [2*DPW-1:0] p;
        if (cyc == m_mode_at) m_mode = m_req;
        if (m_phase == 0) begin
            if (v) begin
                p          = (2*DPW)'(a) * (2*DPW)'(b);
                m_res      = p[RW-1:0];
                m_req      = apx;
                e_a        = a;
                e_b        = b;
                m_phase    = 1;
                if (apx != m_mode) begin
                    m_done_at  = cyc + SW + LAT;
                    m_pulse_at = cyc;
                    m_mode_at  = cyc + SW;
                end else begin
                    m_done_at  = cyc + LAT;
                end
            end
        end else if (m_phase == 1) begin
            if (cyc == m_done_at) begin
                m_phase = 2;
                e_valid = 1'b1;
                e_d     = m_res;
                e_apx   = m_req;
            end
        end else begin
            if (ordy) begin
                m_phase = 0;
                e_valid = 1'b0;
            end
        end
    endfunction

    task automatic check_all();
        check_eq("in_ready",  bus.in_ready,  m_phase == 0);
        check_eq("out_valid", bus.out_valid, e_valid);
        check_eq("out_d",     bus.out_d,     e_d);
        check_eq("out_apx",   bus.out_apx,   e_apx);
        check_eq("mode",      bus.mode,      m_mode);
        check_eq("mul_racc",  bus.mul_racc,  (cyc == m_pulse_at) && !m_req);
        check_eq("mul_rapx",  bus.mul_rapx,  (cyc == m_pulse_at) &&  m_req);
        check_eq("mul_a",     bus.mul_a,     e_a);
        check_eq("mul_b",     bus.mul_b,     e_b);
    endtask

    task automatic cycle(input logic v, input logic [DPW-1:0] a, input logic [DPW-1:0] b,
                         input logic apx, input logic ordy);
        bus.in_valid  = v;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_apx    = apx;
        bus.out_ready = ordy;
        @(posedge clk);
        cyc++;
        model_edge(v, a, b, apx, ordy);
        #1;
        check_all();
    endtask

    // Reset asserted mid-cycle; outputs must clear before any clock edge.
    task automatic async_reset();
        bus.in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        cyc = 0;
        model_reset();
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_apx    = 1'b0;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst = 1'b0;

        // V1: matching mode, first accept right after reset release
        cycle(1, 3, 5, 0, 0);
        check_eq("v1_no_pulse", {bus.mul_racc, bus.mul_rapx}, 0);
        cycle(0, 0, 0, 0, 0);
        check_eq("v1_not_yet", bus.out_valid, 0);
        cycle(0, 0, 0, 0, 0);
        check_eq("v1_valid", bus.out_valid, 1);
        check_eq("v1_out_d", bus.out_d, 15);
        check_eq("v1_out_apx", bus.out_apx, 0);
        cycle(0, 0, 0, 0, 1);

        // V2: switch to approximate
        cycle(1, 7, 9, 1, 0);
        check_eq("v2_rapx", bus.mul_rapx, 1);
        cycle(0, 0, 0, 0, 0);
        check_eq("v2_rapx_once", bus.mul_rapx, 0);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        check_eq("v2_not_yet", bus.out_valid, 0);
        cycle(0, 0, 0, 0, 0);
        check_eq("v2_valid", bus.out_valid, 1);
        check_eq("v2_out_d", bus.out_d, 63);
        check_eq("v2_mode", bus.mode, 1);
        cycle(0, 0, 0, 0, 1);

        // V3: switch back to accurate
        cycle(1, 4, 6, 0, 0);
        check_eq("v3_racc", bus.mul_racc, 1);
        check_eq("v3_rapx", bus.mul_rapx, 0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0);
        check_eq("v3_out_d", bus.out_d, 24);
        check_eq("v3_mode", bus.mode, 0);
        cycle(0, 0, 0, 0, 1);

        // V4: hold for 5 cycles with ignored requests
        cycle(1, 11, 13, 0, 0);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cycle(1, DPW'($urandom), DPW'($urandom), 1'($urandom), 0);
            check_eq("v4_hold_d", bus.out_d, 143);
            check_eq("v4_hold_rdy", bus.in_ready, 0);
        end

        // V6: release and request in the same cycle
        cycle(1, 5, 6, 0, 1);
        check_eq("v6_not_taken", bus.mul_a, 11);
        cycle(1, 5, 6, 0, 0);
        check_eq("v6_taken", bus.mul_a, 5);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1);
        check_eq("v6_out_d", bus.out_d, 30);
        cycle(0, 0, 0, 0, 1);

        // V5: reset in WAIT discards the request
        cycle(1, 2, 2, 0, 0);
        async_reset();
        for (int i = 0; i < LAT + SW + 2; i++) begin
            cycle(0, 0, 0, 0, 1);
            check_eq("v5_no_result", bus.out_valid, 0);
        end

        // Reset in the middle of SWITCH
        cycle(1, 9, 9, 1, 0);
        async_reset();
        check_eq("sw_rst_mode", bus.mode, 0);
        cycle(0, 0, 0, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic [DPW-1:0] ra, rb;
            ra = ($urandom_range(0, 1) == 1) ? DPW'($urandom_range(0, 255)) : DPW'($urandom);
            rb = ($urandom_range(0, 1) == 1) ? DPW'($urandom_range(0, 255)) : DPW'($urandom);
            cycle(1'($urandom_range(0, 1)), ra, rb, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 3) != 0));
            if ($urandom_range(0, 59) == 0) async_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
